// File: rtl/vlsu_ar_sched_if.sv
// AR scheduler bus: requester AR side, downstream AR/R channel and per-requester R steering.
// The scheduler connects through the master modport; its environment connects through the slave modport.
interface vlsu_ar_sched_if #(
   parameter int NrReq          = 2,
   parameter int AxiAddrWidth   = 64,
   parameter int MaxOutstanding = 4
);
   localparam int IdxW = $clog2(NrReq);
   localparam int CntW = $clog2(MaxOutstanding) + 1;

   logic [NrReq-1:0]                   req_valid_i;
   logic [NrReq-1:0][AxiAddrWidth-1:0] req_addr_i;
   logic [NrReq-1:0][7:0]              req_len_i;
   logic [NrReq-1:0]                   req_ready_o;
   logic                               ar_valid_o;
   logic [AxiAddrWidth-1:0]            ar_addr_o;
   logic [7:0]                         ar_len_o;
   logic                               ar_ready_i;
   logic                               r_valid_i;
   logic                               r_last_i;
   logic                               r_ready_o;
   logic [NrReq-1:0]                   r_valid_o;
   logic [NrReq-1:0]                   r_ready_i;
   logic [IdxW-1:0]                    r_owner_o;
   logic [CntW-1:0]                    outstanding_o;
   logic                               error_o;

   modport master (
      input  req_valid_i, req_addr_i, req_len_i, ar_ready_i, r_valid_i, r_last_i, r_ready_i,
      output req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, r_ready_o, r_valid_o, r_owner_o,
             outstanding_o, error_o
   );

   modport slave (
      output req_valid_i, req_addr_i, req_len_i, ar_ready_i, r_valid_i, r_last_i, r_ready_i,
      input  req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, r_ready_o, r_valid_o, r_owner_o,
             outstanding_o, error_o
   );
endinterface

// File: rtl/vlsu_ar_sched.sv
// Round-robin AR arbiter with a registered AR slice and an in-order owner FIFO
// that steers R beats back to the requester that issued each burst.
module vlsu_ar_sched #(
   parameter int NrReq          = 2,
   parameter int AxiAddrWidth   = 64,
   parameter int MaxOutstanding = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   vlsu_ar_sched_if.master bus
);
   localparam int IdxW = $clog2(NrReq);
   localparam int PtrW = $clog2(MaxOutstanding);
   localparam int CntW = PtrW + 1;

   typedef logic [IdxW-1:0] idx_t;

   idx_t                    rr_q;
   idx_t                    grant_idx;
   idx_t                    owner;
   logic                    grant;
   logic [NrReq-1:0]        grant_oh;
   logic [2*NrReq-1:0]      rot;
   int                      off;

   logic                    ar_valid_q;
   logic [AxiAddrWidth-1:0] ar_addr_q;
   logic [7:0]              ar_len_q;

   idx_t                    owner_mem [MaxOutstanding];
   logic [PtrW-1:0]         wptr_q;
   logic [PtrW-1:0]         rptr_q;
   logic [CntW-1:0]         cnt_q;
   logic                    error_q;

   logic                    fifo_empty;
   logic                    slot_free;
   logic                    pop;

   assign fifo_empty = (cnt_q == '0);
   // Uses the registered count only, so a pop at full never frees a slot in the same cycle.
   assign slot_free  = (!ar_valid_q || bus.ar_ready_i) && (cnt_q < CntW'(MaxOutstanding));

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      rot = {bus.req_valid_i, bus.req_valid_i} >> rr_q;
      off = 0;
      for (int i = NrReq - 1; i >= 0; i--) begin
         if (rot[i]) off = i;
      end
      grant_idx = idx_t'((int'(rr_q) + off) % NrReq);
      grant     = slot_free && (|bus.req_valid_i);
      grant_oh  = grant ? (NrReq'(1) << grant_idx) : '0;
   end

   assign owner = fifo_empty ? '0 : owner_mem[rptr_q];
   assign pop   = !fifo_empty && bus.r_valid_i && bus.r_ready_i[owner] && bus.r_last_i;

   assign bus.req_ready_o   = grant_oh;
   assign bus.ar_valid_o    = ar_valid_q;
   assign bus.ar_addr_o     = ar_addr_q;
   assign bus.ar_len_o      = ar_len_q;
   assign bus.r_owner_o     = owner;
   assign bus.r_ready_o     = !fifo_empty && bus.r_ready_i[owner];
   assign bus.r_valid_o     = fifo_empty ? '0 : (NrReq'(bus.r_valid_i) << owner);
   assign bus.outstanding_o = cnt_q;
   assign bus.error_o       = error_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         ar_valid_q <= 1'b0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         error_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (grant) begin
            ar_valid_q <= 1'b1;
            ar_addr_q  <= bus.req_addr_i[grant_idx];
            ar_len_q   <= bus.req_len_i[grant_idx];
            rr_q       <= (grant_idx == idx_t'(NrReq - 1)) ? '0 : grant_idx + 1'b1;
            wptr_q     <= wptr_q + 1'b1;
         end else if (bus.ar_ready_i) begin
            ar_valid_q <= 1'b0;
         end

         if (pop) rptr_q <= rptr_q + 1'b1;

         case ({grant, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase

         if (bus.r_valid_i && fifo_empty) error_q <= 1'b1;
      end
   end

   // NOTE: owner storage has no reset; an entry is only read while cnt_q marks it valid.
   always_ff @(posedge clk_i) begin
      if (grant) owner_mem[wptr_q] <= grant_idx;
   end
endmodule

// File: tb/tb_vlsu_ar_sched.sv
// Self-checking bench for vlsu_ar_sched: directed table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_vlsu_ar_sched;
   localparam int N  = 2;
   localparam int AW = 64;
   localparam int MO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   vlsu_ar_sched_if #(.NrReq(N), .AxiAddrWidth(AW), .MaxOutstanding(MO)) bus ();

   vlsu_ar_sched #(.NrReq(N), .AxiAddrWidth(AW), .MaxOutstanding(MO)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] rv, input logic ar_rdy, input logic rvi,
                        input logic last, input logic [1:0] rri);
      bus.req_valid_i = rv;
      bus.ar_ready_i  = ar_rdy;
      bus.r_valid_i   = rvi;
      bus.r_last_i    = last;
      bus.r_ready_i   = rri;
   endtask

   // Reference model: bursts in flight are a queue of owner indices.
   int          q[$];
   bit          m_arv;
   logic [63:0] m_addr;
   logic [7:0]  m_len;
   int          m_rr;
   bit          m_err;

   task automatic model_reset();
      q.delete();
      m_arv = 0; m_addr = '0; m_len = '0; m_rr = 0; m_err = 0;
   endtask

   task automatic model_step();
      int   k;
      bit   can, gnt, popped;
      int   own;
      logic [1:0] exp_rdy, exp_rvo;
      logic exp_rro;
      k = -1;
      for (int i = 0; i < N; i++) begin
         int j;
         j = (m_rr + i) % N;
         if (k < 0 && bus.req_valid_i[j]) k = j;
      end
      can     = (!m_arv || bus.ar_ready_i) && (q.size() < MO);
      gnt     = can && (k >= 0);
      exp_rdy = gnt ? (2'b01 << k) : 2'b00;
      own     = (q.size() > 0) ? q[0] : 0;
      exp_rro = (q.size() > 0) && bus.r_ready_i[own];
      exp_rvo = (q.size() > 0 && bus.r_valid_i) ? (2'b01 << own) : 2'b00;

      check("rnd_req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
      check("rnd_ar_valid", 64'(bus.ar_valid_o), 64'(m_arv));
      if (m_arv) begin
         check("rnd_ar_addr", bus.ar_addr_o, m_addr);
         check("rnd_ar_len", 64'(bus.ar_len_o), 64'(m_len));
      end
      check("rnd_outstanding", 64'(bus.outstanding_o), 64'(q.size()));
      check("rnd_r_owner", 64'(bus.r_owner_o), 64'(own));
      check("rnd_r_ready", 64'(bus.r_ready_o), 64'(exp_rro));
      check("rnd_r_valid", 64'(bus.r_valid_o), 64'(exp_rvo));
      check("rnd_error", 64'(bus.error_o), 64'(m_err));

      popped = (q.size() > 0) && bus.r_valid_i && exp_rro && bus.r_last_i;
      if (bus.r_valid_i && q.size() == 0) m_err = 1;
      if (popped) void'(q.pop_front());
      if (gnt) begin
         q.push_back(k);
         m_rr   = (k + 1) % N;
         m_arv  = 1;
         m_addr = bus.req_addr_i[k];
         m_len  = bus.req_len_i[k];
      end else if (bus.ar_ready_i) begin
         m_arv = 0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
      bus.req_addr_i = '0;
      bus.req_len_i  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      next_cycle();
   endtask

   typedef struct {
      logic [1:0] rv;
      logic       rvi;
      logic       last;
      logic [1:0] exp_rdy;
      int         exp_out;
      int         exp_owner;
      logic [1:0] exp_rvo;
      logic       exp_rro;
   } row_t;

   row_t tbl[14];

   initial begin
      tbl[0]  = '{2'b11, 1'b0, 1'b0, 2'b01, 0, 0, 2'b00, 1'b0};
      tbl[1]  = '{2'b11, 1'b0, 1'b0, 2'b10, 1, 0, 2'b00, 1'b1};
      tbl[2]  = '{2'b11, 1'b0, 1'b0, 2'b01, 2, 0, 2'b00, 1'b1};
      tbl[3]  = '{2'b11, 1'b0, 1'b0, 2'b10, 3, 0, 2'b00, 1'b1};
      tbl[4]  = '{2'b11, 1'b0, 1'b0, 2'b00, 4, 0, 2'b00, 1'b1};
      tbl[5]  = '{2'b01, 1'b1, 1'b1, 2'b00, 4, 0, 2'b01, 1'b1};
      tbl[6]  = '{2'b01, 1'b0, 1'b0, 2'b01, 3, 1, 2'b00, 1'b1};
      tbl[7]  = '{2'b01, 1'b0, 1'b0, 2'b00, 4, 1, 2'b00, 1'b1};
      tbl[8]  = '{2'b00, 1'b1, 1'b0, 2'b00, 4, 1, 2'b10, 1'b1};
      tbl[9]  = '{2'b00, 1'b1, 1'b1, 2'b00, 4, 1, 2'b10, 1'b1};
      tbl[10] = '{2'b00, 1'b1, 1'b1, 2'b00, 3, 0, 2'b01, 1'b1};
      tbl[11] = '{2'b00, 1'b1, 1'b1, 2'b00, 2, 1, 2'b10, 1'b1};
      tbl[12] = '{2'b00, 1'b1, 1'b1, 2'b00, 1, 0, 2'b01, 1'b1};
      tbl[13] = '{2'b00, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00, 1'b0};

      // Reset state, sampled while reset is held
      rst_n = 1'b0;
      drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
      bus.req_addr_i = '0;
      bus.req_len_i  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ar_valid", 64'(bus.ar_valid_o), 64'd0);
      check("rst_ar_addr", bus.ar_addr_o, 64'd0);
      check("rst_ar_len", 64'(bus.ar_len_o), 64'd0);
      check("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
      check("rst_error", 64'(bus.error_o), 64'd0);
      check("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
      check("rst_r_ready", 64'(bus.r_ready_o), 64'd0);

      // Directed table: alternate grants to full, full-blocking pop, in-order R routing
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].rv, 1'b1, tbl[i].rvi, tbl[i].last, 2'b11);
         @(negedge clk);
         check($sformatf("tbl%0d_req_ready", i), 64'(bus.req_ready_o), 64'(tbl[i].exp_rdy));
         check($sformatf("tbl%0d_outstanding", i), 64'(bus.outstanding_o), 64'(tbl[i].exp_out));
         check($sformatf("tbl%0d_r_owner", i), 64'(bus.r_owner_o), 64'(tbl[i].exp_owner));
         check($sformatf("tbl%0d_r_valid", i), 64'(bus.r_valid_o), 64'(tbl[i].exp_rvo));
         check($sformatf("tbl%0d_r_ready", i), 64'(bus.r_ready_o), 64'(tbl[i].exp_rro));
         next_cycle();
      end
      check("tbl_error", 64'(bus.error_o), 64'd0);

      // AR backpressure: registered addr/len held, no grant until the drain cycle
      do_reset();
      bus.req_addr_i[1] = 64'h1000;
      bus.req_len_i[1]  = 8'd3;
      drive(2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
      @(negedge clk);
      check("bp_grant1", 64'(bus.req_ready_o), 64'b10);
      check("bp_ar_valid_pre", 64'(bus.ar_valid_o), 64'd0);
      next_cycle();
      bus.req_addr_i[0] = 64'h3000;
      bus.req_len_i[0]  = 8'd5;
      bus.req_addr_i[1] = 64'h2000;
      bus.req_len_i[1]  = 8'd7;
      drive(2'b11, 1'b0, 1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_ar_valid", 64'(bus.ar_valid_o), 64'd1);
         check("bp_ar_addr", bus.ar_addr_o, 64'h1000);
         check("bp_ar_len", 64'(bus.ar_len_o), 64'd3);
         check("bp_no_grant", 64'(bus.req_ready_o), 64'd0);
         check("bp_outstanding", 64'(bus.outstanding_o), 64'd1);
         next_cycle();
      end
      bus.ar_ready_i = 1'b1;
      @(negedge clk);
      check("bp_drain_grant", 64'(bus.req_ready_o), 64'b01);
      check("bp_drain_addr", bus.ar_addr_o, 64'h1000);
      next_cycle();
      drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
      @(negedge clk);
      check("bp_next_addr", bus.ar_addr_o, 64'h3000);
      check("bp_next_len", 64'(bus.ar_len_o), 64'd5);
      check("bp_next_out", 64'(bus.outstanding_o), 64'd2);

      // R beat with empty owner FIFO: not accepted, sticky error
      do_reset();
      drive(2'b00, 1'b1, 1'b1, 1'b1, 2'b11);
      @(negedge clk);
      check("err_r_ready", 64'(bus.r_ready_o), 64'd0);
      check("err_r_valid", 64'(bus.r_valid_o), 64'd0);
      check("err_pre", 64'(bus.error_o), 64'd0);
      next_cycle();
      bus.r_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("err_sticky", 64'(bus.error_o), 64'd1);
         next_cycle();
      end

      // Asynchronous reset mid-burst
      do_reset();
      bus.req_addr_i[0] = 64'h40;
      bus.req_addr_i[1] = 64'h80;
      drive(2'b01, 1'b1, 1'b0, 1'b0, 2'b11);
      next_cycle();
      drive(2'b10, 1'b1, 1'b0, 1'b0, 2'b11);
      next_cycle();
      drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b11);
      @(negedge clk);
      check("mid_outstanding", 64'(bus.outstanding_o), 64'd2);
      check("mid_ar_valid", 64'(bus.ar_valid_o), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_ar_valid", 64'(bus.ar_valid_o), 64'd0);
      check("mid_rst_ar_addr", bus.ar_addr_o, 64'd0);
      check("mid_rst_outstanding", 64'(bus.outstanding_o), 64'd0);
      check("mid_rst_r_ready", 64'(bus.r_ready_o), 64'd0);
      check("mid_rst_r_owner", 64'(bus.r_owner_o), 64'd0);
      #1 rst_n = 1'b1;
      next_cycle();
      drive(2'b11, 1'b1, 1'b1, 1'b1, 2'b11);
      @(negedge clk);
      check("post_rst_grant", 64'(bus.req_ready_o), 64'b01);
      check("post_rst_r_ready", 64'(bus.r_ready_o), 64'd0);
      next_cycle();
      drive(2'b00, 1'b1, 1'b0, 1'b0, 2'b11);
      @(negedge clk);
      check("post_rst_error", 64'(bus.error_o), 64'd1);
      check("post_rst_out", 64'(bus.outstanding_o), 64'd1);

      // Randomized traffic against the reference model
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         bus.req_valid_i   = 2'($urandom_range(0, 3));
         bus.req_addr_i[0] = {$urandom, $urandom};
         bus.req_addr_i[1] = {$urandom, $urandom};
         bus.req_len_i[0]  = 8'($urandom);
         bus.req_len_i[1]  = 8'($urandom);
         bus.ar_ready_i    = ($urandom_range(0, 3) != 0);
         bus.r_valid_i     = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         bus.r_last_i      = ($urandom_range(0, 2) == 0);
         bus.r_ready_i     = 2'($urandom_range(0, 3));
         @(negedge clk);
         model_step();
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vlsu_ar_sched.md
VLSU_AR_SCHED -- requirements
Module: vlsu_ar_sched

Interface
REQ-001 SHALL have parameter NrReq, default 2, number of AR requesters (e.g. vector load path, scalar/other port); legal range 2..8.
REQ-002 SHALL have parameter AxiAddrWidth, default 64, AR address width.
REQ-003 SHALL have parameter MaxOutstanding, default 4, maximum bursts in flight (AR issued or pending, last R beat not yet accepted); must be a power of two, at least 2.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
REQ-005 clk_i  in  1  single clock, all state on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  in  NrReq  per-requester AR request valid.
REQ-008 req_addr_i  in  NrReq x AxiAddrWidth  per-requester burst address.
REQ-009 req_len_i  in  NrReq x 8  per-requester AXI len (beats-1).
REQ-010 req_ready_o  out  NrReq  one-hot grant; a request is accepted when valid and ready are both high.
REQ-011 ar_valid_o, ar_addr_o, ar_len_o  out  1, AxiAddrWidth, 8  downstream AR channel.
REQ-012 ar_ready_i  in  1  downstream AR ready.
REQ-013 r_valid_i, r_last_i  in  1, 1  downstream R beat valid and last flag.
REQ-014 r_ready_o  out  1  downstream R ready.
REQ-015 r_valid_o  out  NrReq  R beat steered to its owning requester.
REQ-016 r_ready_i  in  NrReq  per-requester R ready.
REQ-017 r_owner_o  out  $clog2(NrReq)  index of the current R beat's owner, used by the external data mux.
REQ-018 outstanding_o  out  $clog2(MaxOutstanding)+1  count of in-flight bursts.
REQ-019 error_o  out  1  sticky protocol error flag.

Function
REQ-020 Arbitration SHALL be round-robin over req_valid_i, with the search starting at pointer rr_q; at most one req_ready_o bit SHALL be high per cycle.
REQ-021 A grant SHALL occur only when the AR output register is empty or being drained (ar_valid_o && ar_ready_i) and outstanding_o < MaxOutstanding; otherwise req_ready_o SHALL be all zero.
REQ-022 On a grant to index k, rr_q SHALL become (k+1) mod NrReq; without a grant rr_q SHALL hold.
REQ-023 Accepted address and len SHALL be registered: ar_valid_o rises in the cycle after acceptance (1-cycle latency), and ar_addr_o/ar_len_o SHALL be stable while ar_valid_o && !ar_ready_i.
REQ-024 On acceptance, k SHALL be pushed into an owner FIFO of depth MaxOutstanding, and outstanding_o SHALL increment.
REQ-025 With the owner FIFO non-empty, r_owner_o SHALL equal the FIFO head, r_valid_o SHALL equal r_valid_i on bit r_owner_o (zero elsewhere), and r_ready_o SHALL equal r_ready_i[r_owner_o]; all of this SHALL be combinational, with no added latency.
REQ-026 On r_valid_i && r_ready_o && r_last_i, the FIFO SHALL pop and outstanding_o SHALL decrement.
REQ-027 A simultaneous push and pop SHALL leave outstanding_o unchanged and SHALL preserve FIFO order.
REQ-028 A grant SHALL NOT be issued in the same cycle as a pop when outstanding_o == MaxOutstanding (no full-bypass).
REQ-029 With the FIFO empty: r_ready_o=0, r_valid_o=0, r_owner_o=0; if r_valid_i is high, error_o SHALL set and remain set until reset.
REQ-030 FIFO pointers SHALL wrap modulo MaxOutstanding.

Reset
REQ-031 On rst_ni low, regardless of clock, SHALL clear: ar_valid_o=0, ar_addr_o=0, ar_len_o=0, rr_q=0, FIFO empty, outstanding_o=0, error_o=0; as a result req_ready_o, r_valid_o, r_ready_o and r_owner_o are 0.
REQ-032 Reset mid-burst SHALL discard all in-flight ownership without any R handshake; after release, the first grant SHALL go to the lowest valid index.

Verification
REQ-033 Both requesters valid continuously, ar_ready_i=1, R idle -> grants alternate 0,1,0,1 until outstanding_o=4, then req_ready_o=0.
REQ-034 Grant to req 1 (addr 0x1000, len 3), ar_ready_i low for 3 cycles -> ar_valid_o high from the cycle after grant, addr/len stable, no new grant until the drain cycle.
REQ-035 Bursts issued to owners 0,1,0 with lens 0,1,0 -> R beats routed in order 0,1,1,0, r_owner_o matching each beat, outstanding_o returning to 0.
REQ-036 outstanding_o=4 and a last beat accepted while req 0 valid -> no grant that cycle; grant next cycle; outstanding_o reads 3 then 4.
REQ-037 r_valid_i=1 with FIFO empty -> r_ready_o=0, error_o=1 and held.
REQ-038 rst_ni asserted with 2 outstanding and ar_valid_o high -> all outputs 0 immediately; post-reset R beats set error_o.
